// File: rtl/ss_dispatch_pkg.sv
// Shared bridge definitions for slave-select dispatch.
// FSM encoding, address width and default window timing.
package ss_dispatch_pkg;

  localparam int SS_ADDR_W    = 8;
  localparam int SS_SETUP_DEF = 2;
  localparam int SS_HOLD_DEF  = 2;
  localparam int SS_GAP_DEF   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } ss_state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ss_dispatch_if.sv
// Queue-read and shift-engine handshake bundle.
// master = dispatcher side, slave = queue/engine side.
interface ss_dispatch_if;
  import ss_dispatch_pkg::*;

  logic                 q_empty;
  logic                 q_rd_en;
  logic [SS_ADDR_W-1:0] q_slave_addr;
  logic                 xfer_start;
  logic                 xfer_done;

  modport master (
    input  q_empty,
    input  q_slave_addr,
    input  xfer_done,
    output q_rd_en,
    output xfer_start
  );

  modport slave (
    output q_empty,
    output q_slave_addr,
    output xfer_done,
    input  q_rd_en,
    input  xfer_start
  );

endinterface

// File: rtl/ss_decode.sv
// Address to active-low one-hot chip-select decoder.
// oor flags addresses with no matching select line.
module ss_decode
  import ss_dispatch_pkg::*;
#(
  parameter int NUM_SLAVES = 8
) (
  input  logic [SS_ADDR_W-1:0]  addr,
  output logic [NUM_SLAVES-1:0] ss_n,
  output logic                  oor
);

  localparam logic [SS_ADDR_W:0] LIMIT =
    NUM_SLAVES[SS_ADDR_W:0];

  always_comb begin
    ss_n = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (addr == SS_ADDR_W'(i)) ss_n[i] = 1'b0;
    end
  end

  assign oor = ({1'b0, addr} >= LIMIT);

endmodule

// File: rtl/ss_dispatch.sv
// Slave-select dispatcher: pops queued addresses and
// frames each SPI transfer with setup/hold/gap windows.
module ss_dispatch
  import ss_dispatch_pkg::*;
#(
  parameter int NUM_SLAVES   = 8,
  parameter int SETUP_CYCLES = SS_SETUP_DEF,
  parameter int HOLD_CYCLES  = SS_HOLD_DEF,
  parameter int GAP_CYCLES   = SS_GAP_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  ss_dispatch_if.master         bus,
  output logic [NUM_SLAVES-1:0] ss_n,
  output logic                  busy,
  output logic                  addr_err,
  output logic [SS_ADDR_W-1:0]  cur_addr
);

  localparam int CNT_MAX =
    max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LD =
    CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  ss_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic cnt_last;

  logic [NUM_SLAVES-1:0] dec_ss_n;
  logic dec_oor;

  ss_decode #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_decode (
    .addr (bus.q_slave_addr),
    .ss_n (dec_ss_n),
    .oor  (dec_oor)
  );

  // Counter parks at 1 rather than wrapping.
  assign cnt_last = (cnt <= CNT_ONE);

  assign bus.q_rd_en    = (state == ST_POP);
  assign bus.xfer_start = (state == ST_SETUP) && cnt_last;
  assign busy           = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (enable && !bus.q_empty) state_nxt = ST_POP;
      end
      ST_POP: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (dec_oor) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_last) state_nxt = ST_XFER;
        else          cnt_nxt   = cnt - CNT_ONE;
      end
      ST_XFER: begin
        if (bus.xfer_done) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_last) state_nxt = ST_IDLE;
        else          cnt_nxt   = cnt - CNT_ONE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_n     <= '1;
      addr_err <= 1'b0;
      cur_addr <= '0;
    end else begin
      addr_err <= (state == ST_LOAD) && dec_oor;
      if (state == ST_LOAD) begin
        cur_addr <= bus.q_slave_addr;
        if (!dec_oor) ss_n <= dec_ss_n;
      end else if (state == ST_HOLD && cnt_last) begin
        ss_n <= '1;
      end
    end
  end

endmodule
